// File: rtl/alu_pkg.sv
// alu_pkg: shared types and flag bit positions for the ALU flag path
package alu_pkg;
  typedef enum logic [2:0] {EQ, NE, LT, GE, CS, CC, MI, AL} cond_e;
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/alu_flags_reg_if.sv
// alu_flags_reg_if: ALU result/flag capture, query handshake and status outputs
interface alu_flags_reg_if #(parameter int N = 4);
  import alu_pkg::*;
  logic [N-1:0] result;
  logic         z_in;
  logic         c_in;
  logic         v_in;
  logic         flag_we;
  logic         cond_req;
  cond_e        cond;
  logic         clr_sticky;
  logic         cond_ack;
  logic         cond_true;
  logic [3:0]   flags;
  logic         sticky_v;
  logic         z_err;
  modport master (
    output result, z_in, c_in, v_in, flag_we, cond_req, cond, clr_sticky,
    input  cond_ack, cond_true, flags, sticky_v, z_err
  );
  modport slave (
    input  result, z_in, c_in, v_in, flag_we, cond_req, cond, clr_sticky,
    output cond_ack, cond_true, flags, sticky_v, z_err
  );
endinterface

// File: rtl/alu_flags_reg_cond_eval.sv
// cond_eval: combinational condition-code evaluation over {N,Z,C,V}
module cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] flags_i,
  input  cond_e      cond_i,
  output logic       true_o
);
  logic n, z, c, v;
  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];
  always_comb begin
    true_o = 1'b1;
    case (cond_i)
      EQ:      true_o = z;
      NE:      true_o = !z;
      LT:      true_o = n ^ v;
      GE:      true_o = !(n ^ v);
      CS:      true_o = c;
      CC:      true_o = !c;
      MI:      true_o = n;
      default: true_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_flags_reg.sv
// alu_flags_reg: registered NZCV flags, sticky overflow, Z cross-check and
// REQ/ACK condition-code query FSM
module alu_flags_reg
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input logic            clk,
  input logic            rst_n,
  alu_flags_reg_if.slave bus
);
  logic [3:0] flags_q, flags_d;
  logic       sticky_q, sticky_d;
  logic       zerr_q, zerr_d;
  logic       ack_q, true_q, eval_true;
  state_e     state_q, state_d;
  always_comb begin
    flags_d = flags_q;
    if (bus.flag_we) begin
      flags_d[FLAG_N] = bus.result[N-1];
      flags_d[FLAG_Z] = bus.z_in;
      flags_d[FLAG_C] = bus.c_in;
      flags_d[FLAG_V] = bus.v_in;
    end
    sticky_d = (bus.flag_we && bus.v_in) || (sticky_q && !bus.clr_sticky);
    zerr_d   = zerr_q || (bus.flag_we && (bus.z_in != (bus.result == '0)));
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.cond_req ? (bus.flag_we ? WAIT : ACK) : IDLE;
      WAIT:    state_d = ACK;
      default: state_d = IDLE;
    endcase
  end
  // Evaluated on the next-state flags so the registered result matches the
  // flags that are visible during the ACK cycle.
  cond_eval u_eval (
    .flags_i (flags_d),
    .cond_i  (bus.cond),
    .true_o  (eval_true)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q  <= '0;
      sticky_q <= 1'b0;
      zerr_q   <= 1'b0;
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      true_q   <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      sticky_q <= sticky_d;
      zerr_q   <= zerr_d;
      state_q  <= state_d;
      ack_q    <= state_d == ACK;
      true_q   <= (state_d == ACK) && eval_true;
    end
  end
  assign bus.flags     = flags_q;
  assign bus.sticky_v  = sticky_q;
  assign bus.z_err     = zerr_q;
  assign bus.cond_ack  = ack_q;
  assign bus.cond_true = true_q;
endmodule

// File: doc/alu_flags_reg.md
# alu_flags_reg

Registered status-flag unit at the output side of the ALU. Each valid ALU result is captured into N, Z, C and V flags. The unit cross-checks the zero detector's Z against its own reduction of the result bus and serves condition-code queries from the control FSM over a REQ/ACK handshake. It is the consumer end of the ALU flag path: the zero detector and adder produce the flags, and this block stores, checks and evaluates them.

## Interface
Parameters:
- N, 4, ALU datapath width; must match the zero detector instance.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST_N  in  1  reset, asynchronous and active-low.
- RESULT  in  N  ALU result bus.
- Z_IN  in  1  zero flag from the zero detector for RESULT.
- C_IN  in  1  carry-out from the ALU.
- V_IN  in  1  signed overflow from the ALU.
- FLAG_WE  in  1  RESULT, Z_IN, C_IN and V_IN are valid this cycle; capture them.
- COND_REQ  in  1  condition query request, level-held until COND_ACK.
- COND  in  3  condition selector, stable while COND_REQ is high.
- COND_ACK  out  1  one-cycle pulse; COND_TRUE is valid in the same cycle.
- COND_TRUE  out  1  result of the condition evaluation.
- FLAGS  out  4  registered {N,Z,C,V}.
- STICKY_V  out  1  set by any captured overflow.
- CLR_STICKY  in  1  clears STICKY_V.
- Z_ERR  out  1  sticky mismatch between Z_IN and (RESULT==0).

## Operation
- Capture on FLAG_WE:
  - N takes RESULT[N-1], Z takes Z_IN, C takes C_IN, V takes V_IN.
  - With FLAG_WE low, all four flags hold.
- Z check: if FLAG_WE and Z_IN != (RESULT == 0), Z_ERR sets. Only reset clears Z_ERR.
- STICKY_V:
  - Sets when FLAG_WE && V_IN.
  - CLR_STICKY clears it.
  - If set and clear occur in the same cycle, set wins.
- COND encoding:
  - 0 EQ = Z
  - 1 NE = !Z
  - 2 LT = N^V
  - 3 GE = !(N^V)
  - 4 CS = C
  - 5 CC = !C
  - 6 MI = N
  - 7 AL = 1
- FSM states: IDLE, WAIT, ACK.
  - IDLE, COND_REQ high, FLAG_WE low: go to ACK.
  - IDLE, COND_REQ high, FLAG_WE high: go to WAIT, so the query sees the flags being written.
  - WAIT: go to ACK unconditionally.
  - ACK: COND_ACK=1 and COND_TRUE is the evaluation of the registered flags; go to IDLE.
  - IDLE, COND_REQ low: stay in IDLE.
- The requester drops COND_REQ in the cycle after it sees COND_ACK. If COND_REQ is still high when the FSM is back in IDLE, the FSM treats it as a new query.
- FLAG_WE asserted while in WAIT or ACK: flags update normally. COND_TRUE in ACK reflects the registered flags at that cycle. It does not reflect values being written on the same edge.

## Timing
- Reset values (asynchronous, immediate on RST_N low):
  - FLAGS=4'b0000, STICKY_V=0, Z_ERR=0.
  - COND_ACK=0, COND_TRUE=0, state IDLE.
- Flag latency: FLAG_WE sampled at edge k gives FLAGS valid after edge k.
- Query latency, counted from the first edge at which COND_REQ is sampled high in IDLE:
  - No FLAG_WE at that edge: COND_ACK high in the following cycle (1 cycle).
  - FLAG_WE at that edge: COND_ACK high 2 cycles later.
- COND_ACK is never high for two consecutive cycles.
- COND_TRUE and COND_ACK are registered outputs with no combinational path from the inputs.
- Reset during WAIT or ACK aborts the query with no ACK. The requester must reissue the query after reset.

## Structure
- Package alu_pkg holds:
  - cond_e enum (EQ, NE, LT, GE, CS, CC, MI, AL; 3 bits).
  - fsm state enum.
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One combinational sub-module, cond_eval: inputs flags[3:0] and cond_e, output a true bit. It is reused later by the branch unit.
- Top level holds the flag register, the sticky and error logic, and the FSM.

## Test plan
- Reset check: hold RST_N=0 with arbitrary inputs toggling → FLAGS=0000, COND_ACK=0, Z_ERR=0, STICKY_V=0 throughout.
- Flag capture and query:
  - FLAG_WE with RESULT=4'b0000, Z_IN=1, C_IN=1, V_IN=0 → FLAGS=0110.
  - Then COND_REQ with COND=EQ → COND_ACK one cycle later, COND_TRUE=1.
  - Repeat with COND=CC → COND_TRUE=0.
- Hazard:
  - FLAGS start at 0000.
  - COND_REQ (COND=MI) in the same cycle as FLAG_WE with RESULT=4'b1000, V_IN=1 → ACK after 2 cycles, COND_TRUE=1.
  - STICKY_V=1.
- Signed compare: FLAG_WE with RESULT=4'b1001, V_IN=1 → COND=LT gives COND_TRUE=0 and COND=GE gives 1.
- Sticky priority and Z mismatch:
  - CLR_STICKY and FLAG_WE with V_IN=1 in the same cycle → STICKY_V stays 1.
  - FLAG_WE with RESULT=4'b0011, Z_IN=1 → Z_ERR=1, and it persists through 10 later clean writes.
- Reset mid-query: assert RST_N=0 in WAIT → no COND_ACK pulse. After release, a new query with COND=AL → COND_TRUE=1.
